// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor with a tagged direct-mapped BTB.
// Each fetch lane looks up a pattern table indexed by PC XOR speculative history,
// and the speculative history advances at fetch. A mispredict restores it.
// Up to UPD_W committed branches per cycle train the counters and the BTB in program order.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module gshare_branch_predictor #(
    parameter int WAY      = 2,
    parameter int UPD_W    = 2,
    parameter int XLEN     = 32,
    parameter int HIST_LEN = 8,
    parameter int PHT_IDX  = 8,
    parameter int BTB_IDX  = 6,
    parameter int CTR_BITS = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WAY-1:0]           fetch_valid,
    input  logic [WAY*XLEN-1:0]      fetch_pc,
    output logic [WAY-1:0]           pred_valid,
    output logic [WAY-1:0]           pred_taken,
    output logic [WAY*XLEN-1:0]      pred_target,
    output logic [WAY*HIST_LEN-1:0]  pred_hist,
    input  logic [UPD_W-1:0]         upd_valid,
    input  logic [UPD_W*XLEN-1:0]    upd_pc,
    input  logic [UPD_W*HIST_LEN-1:0] upd_hist,
    input  logic [UPD_W-1:0]         upd_taken,
    input  logic [UPD_W*XLEN-1:0]    upd_target,
    input  logic                     recover_valid,
    input  logic [HIST_LEN-1:0]      recover_hist,
    input  logic                     recover_taken
`ifdef BP_STATS_EN
    ,
    output logic [31:0]              stat_lookups,
    output logic [31:0]              stat_taken,
    output logic [31:0]              stat_recovers
`endif
);

    localparam int PHT_DEPTH = 1 << PHT_IDX;
    localparam int BTB_DEPTH = 1 << BTB_IDX;
    localparam int TAG_W     = XLEN - BTB_IDX - 2;

    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX     = {CTR_BITS{1'b1}};

    function automatic logic [BTB_IDX-1:0] btb_index(input logic [XLEN-1:0] pc);
        return pc[BTB_IDX+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] btb_tag(input logic [XLEN-1:0] pc);
        return pc[XLEN-1:BTB_IDX+2];
    endfunction

    function automatic logic [PHT_IDX-1:0] pht_index(input logic [XLEN-1:0] pc,
                                                     input logic [HIST_LEN-1:0] hist);
        logic [PHT_IDX-1:0] hist_ext;
        hist_ext                 = '0;
        hist_ext[HIST_LEN-1:0]   = hist;
        return pc[PHT_IDX+1:2] ^ hist_ext;
    endfunction

    // Architectural state
    logic [HIST_LEN-1:0] r_ghr;
    logic [CTR_BITS-1:0] r_pht        [PHT_DEPTH];
    logic [BTB_DEPTH-1:0] r_btb_valid;
    logic [TAG_W-1:0]    r_btb_tag    [BTB_DEPTH];
    logic [XLEN-1:0]     r_btb_target [BTB_DEPTH];

    // Lookup results and per-lane update decisions
    logic [HIST_LEN-1:0] w_fetch_hist_end;
    logic [PHT_IDX-1:0]  w_upd_pht_idx [UPD_W];
    logic [BTB_IDX-1:0]  w_upd_btb_idx [UPD_W];
    logic [CTR_BITS-1:0] w_upd_ctr     [UPD_W];
    logic                w_unused_bits;

    // Combinational lookup of all fetch lanes against registered state, rippling history lane to lane
    always_comb begin : lookup
        logic [HIST_LEN-1:0] h;
        logic [XLEN-1:0]     pc;
        logic [BTB_IDX-1:0]  bi;
        logic                hit;
        logic                tk;
        logic                blocked;
        // NOTE: every output and temporary is given a value before the loop, so no path holds an old value and no latch is inferred.
        h           = r_ghr;
        blocked     = 1'b0;
        pc          = '0;
        bi          = '0;
        hit         = 1'b0;
        tk          = 1'b0;
        pred_valid  = '0;
        pred_taken  = '0;
        pred_target = '0;
        pred_hist   = '0;
        for (int i = 0; i < WAY; i++) begin
            pc  = fetch_pc[i*XLEN +: XLEN];
            bi  = btb_index(pc);
            hit = r_btb_valid[bi] && (r_btb_tag[bi] == btb_tag(pc));
            tk  = hit && r_pht[pht_index(pc, h)][CTR_BITS-1];
            pred_taken[i]                      = tk;
            pred_target[i*XLEN +: XLEN]        = tk ? r_btb_target[bi] : pc + XLEN'(4);
            pred_hist[i*HIST_LEN +: HIST_LEN]  = h;
            pred_valid[i]                      = fetch_valid[i] && !blocked;
            // NOTE: blocking assignments are intentional here: h must ripple through the lanes within one evaluation. Flops below use <= only.
            if (pred_valid[i]) begin
                if (hit) begin
                    h = {h[HIST_LEN-2:0], tk};
                end
                if (tk) begin
                    blocked = 1'b1;
                end
            end
        end
        w_fetch_hist_end = h;
    end

    // Global history: recovery wins, otherwise take the history after the last consumed lane
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (recover_valid) begin
            r_ghr <= {recover_hist[HIST_LEN-2:0], recover_taken};
        end else if (|pred_valid) begin
            r_ghr <= w_fetch_hist_end;
        end
    end

    // Per-lane counter results; each lane sees writes made by earlier lanes in the same cycle
    always_comb begin : update_chain
        logic [CTR_BITS-1:0] ctr [UPD_W];
        logic [PHT_IDX-1:0]  pidx [UPD_W];
        logic [BTB_IDX-1:0]  bidx [UPD_W];
        logic [CTR_BITS-1:0] cur;
        logic                ent_valid;
        logic [TAG_W-1:0]    ent_tag;
        logic [XLEN-1:0]     pc;
        for (int j = 0; j < UPD_W; j++) begin
            ctr[j]  = '0;
            pidx[j] = '0;
            bidx[j] = '0;
        end
        for (int j = 0; j < UPD_W; j++) begin
            pc        = upd_pc[j*XLEN +: XLEN];
            pidx[j]   = pht_index(pc, upd_hist[j*HIST_LEN +: HIST_LEN]);
            bidx[j]   = btb_index(pc);
            cur       = r_pht[pidx[j]];
            ent_valid = r_btb_valid[bidx[j]];
            ent_tag   = r_btb_tag[bidx[j]];
            // Forward the youngest earlier-lane write to the same counter or BTB entry
            for (int k = 0; k < j; k++) begin
                if (upd_valid[k] && (pidx[k] == pidx[j])) begin
                    cur = ctr[k];
                end
                if (upd_valid[k] && upd_taken[k] && (bidx[k] == bidx[j])) begin
                    ent_valid = 1'b1;
                    ent_tag   = btb_tag(upd_pc[k*XLEN +: XLEN]);
                end
            end
            if (!upd_taken[j]) begin
                ctr[j] = (cur == '0) ? cur : cur - CTR_BITS'(1);
            end else if (!ent_valid || (ent_tag != btb_tag(pc))) begin
                ctr[j] = CTR_WEAK_T;
            end else begin
                ctr[j] = (cur == CTR_MAX) ? cur : cur + CTR_BITS'(1);
            end
        end
        for (int j = 0; j < UPD_W; j++) begin
            w_upd_ctr[j]     = ctr[j];
            w_upd_pht_idx[j] = pidx[j];
            w_upd_btb_idx[j] = bidx[j];
        end
    end

    // Counter and BTB-valid training; later lanes overwrite earlier ones to the same entry
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int e = 0; e < PHT_DEPTH; e++) begin
                r_pht[e] <= CTR_WEAK_NT;
            end
            r_btb_valid <= '0;
        end else begin
            for (int j = 0; j < UPD_W; j++) begin
                if (upd_valid[j]) begin
                    r_pht[w_upd_pht_idx[j]] <= w_upd_ctr[j];
                    if (upd_taken[j]) begin
                        r_btb_valid[w_upd_btb_idx[j]] <= 1'b1;
                    end
                end
            end
        end
    end

    // BTB tag and target payload written by taken commits
    // NOTE: the tag/target arrays are deliberately left unreset; the valid bits gate every use of them, while the counters are reset because their reset value is visible to lookups.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int j = 0; j < UPD_W; j++) begin
                if (upd_valid[j] && upd_taken[j]) begin
                    r_btb_tag[w_upd_btb_idx[j]]    <= btb_tag(upd_pc[j*XLEN +: XLEN]);
                    r_btb_target[w_upd_btb_idx[j]] <= upd_target[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Input bits that never affect state: byte offsets of committed PCs and the history bit shifted out on recovery
    always_comb begin
        w_unused_bits = recover_hist[HIST_LEN-1];
        for (int j = 0; j < UPD_W; j++) begin
            w_unused_bits = w_unused_bits ^ (^upd_pc[j*XLEN +: 2]);
        end
    end

`ifdef BP_STATS_EN
    // Free-running statistics, wrapping at 2^32
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_lookups  <= '0;
            stat_taken    <= '0;
            stat_recovers <= '0;
        end else begin
            stat_lookups  <= stat_lookups + 32'($countones(pred_valid));
            stat_taken    <= stat_taken + 32'($countones(pred_taken));
            stat_recovers <= stat_recovers + {31'd0, recover_valid};
        end
    end
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor: directed scenarios followed by
// random traffic compared against a table-level reference model of the predictor.
module tb_gshare_branch_predictor;

    localparam int WAY      = 2;
    localparam int UPD_W    = 2;
    localparam int XLEN     = 32;
    localparam int HIST_LEN = 8;
    localparam int PHT_IDX  = 8;
    localparam int BTB_IDX  = 6;
    localparam int CTR_BITS = 2;

    localparam int unsigned PHT_DEPTH = 1 << PHT_IDX;
    localparam int unsigned BTB_DEPTH = 1 << BTB_IDX;
    localparam int unsigned HMASK     = (1 << HIST_LEN) - 1;
    localparam int unsigned CTR_MAX   = (1 << CTR_BITS) - 1;
    localparam int unsigned CTR_HALF  = 1 << (CTR_BITS - 1);

    logic                      clock = 1'b0;
    logic                      reset;
    logic [WAY-1:0]            fetch_valid;
    logic [WAY*XLEN-1:0]       fetch_pc;
    logic [WAY-1:0]            pred_valid;
    logic [WAY-1:0]            pred_taken;
    logic [WAY*XLEN-1:0]       pred_target;
    logic [WAY*HIST_LEN-1:0]   pred_hist;
    logic [UPD_W-1:0]          upd_valid;
    logic [UPD_W*XLEN-1:0]     upd_pc;
    logic [UPD_W*HIST_LEN-1:0] upd_hist;
    logic [UPD_W-1:0]          upd_taken;
    logic [UPD_W*XLEN-1:0]     upd_target;
    logic                      recover_valid;
    logic [HIST_LEN-1:0]       recover_hist;
    logic                      recover_taken;

    always #5 clock = ~clock;

    gshare_branch_predictor #(
        .WAY(WAY), .UPD_W(UPD_W), .XLEN(XLEN), .HIST_LEN(HIST_LEN),
        .PHT_IDX(PHT_IDX), .BTB_IDX(BTB_IDX), .CTR_BITS(CTR_BITS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_hist     (pred_hist),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_hist      (upd_hist),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .recover_valid (recover_valid),
        .recover_hist  (recover_hist),
        .recover_taken (recover_taken)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain tables of integers
    int unsigned m_pht  [PHT_DEPTH];
    bit          m_bv   [BTB_DEPTH];
    int unsigned m_bt   [BTB_DEPTH];
    int unsigned m_btgt [BTB_DEPTH];
    int unsigned m_ghr;

    function automatic int unsigned m_bidx(int unsigned pc);
        return (pc >> 2) % BTB_DEPTH;
    endfunction

    function automatic int unsigned m_tag(int unsigned pc);
        return pc >> (BTB_IDX + 2);
    endfunction

    function automatic int unsigned m_pidx(int unsigned pc, int unsigned h);
        return ((pc >> 2) % PHT_DEPTH) ^ h;
    endfunction

    task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_ghr = 0;
        for (int e = 0; e < int'(PHT_DEPTH); e++) m_pht[e] = CTR_HALF - 1;
        for (int e = 0; e < int'(BTB_DEPTH); e++) m_bv[e] = 1'b0;
    endtask

    // Commit updates in program order, each seeing the tables left by the previous one
    task automatic model_updates();
        int unsigned pc, h, idx, b, tgt;
        for (int j = 0; j < UPD_W; j++) begin
            if (upd_valid[j]) begin
                pc  = upd_pc[j*XLEN +: XLEN];
                h   = 32'(upd_hist[j*HIST_LEN +: HIST_LEN]);
                tgt = upd_target[j*XLEN +: XLEN];
                idx = m_pidx(pc, h);
                b   = m_bidx(pc);
                if (upd_taken[j]) begin
                    if (!m_bv[b] || m_bt[b] != m_tag(pc)) begin
                        m_bv[b]   = 1'b1;
                        m_bt[b]   = m_tag(pc);
                        m_btgt[b] = tgt;
                        m_pht[idx] = CTR_HALF;
                    end else begin
                        m_btgt[b] = tgt;
                        if (m_pht[idx] < CTR_MAX) m_pht[idx] = m_pht[idx] + 1;
                    end
                end else if (m_pht[idx] > 0) begin
                    m_pht[idx] = m_pht[idx] - 1;
                end
            end
        end
    endtask

    // Compare this cycle's lookup with the model, then advance both across one clock edge
    task automatic step(string tag);
        logic [WAY-1:0]          ev;
        logic [WAY-1:0]          et;
        logic [WAY*XLEN-1:0]     etg;
        logic [WAY*HIST_LEN-1:0] eh;
        int unsigned             h, pc, b, ghr_next;
        bit                      blocked, hit, tk;
        #1;
        h       = m_ghr;
        blocked = 1'b0;
        ev      = '0;
        et      = '0;
        etg     = '0;
        eh      = '0;
        for (int i = 0; i < WAY; i++) begin
            pc  = fetch_pc[i*XLEN +: XLEN];
            b   = m_bidx(pc);
            hit = m_bv[b] && (m_bt[b] == m_tag(pc));
            tk  = hit && (m_pht[m_pidx(pc, h)] >= CTR_HALF);
            et[i]                      = tk;
            etg[i*XLEN +: XLEN]        = XLEN'(tk ? m_btgt[b] : pc + 4);
            eh[i*HIST_LEN +: HIST_LEN] = HIST_LEN'(h);
            ev[i]                      = fetch_valid[i] && !blocked;
            if (ev[i]) begin
                if (hit) h = ((h << 1) | 32'(tk)) & HMASK;
                if (tk) blocked = 1'b1;
            end
        end
        if (recover_valid) ghr_next = ((32'(recover_hist) << 1) | 32'(recover_taken)) & HMASK;
        else               ghr_next = h;
        check({tag, ".valid"},  64'(pred_valid),  64'(ev));
        check({tag, ".taken"},  64'(pred_taken),  64'(et));
        check({tag, ".target"}, 64'(pred_target), 64'(etg));
        check({tag, ".hist"},   64'(pred_hist),   64'(eh));
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            m_ghr = ghr_next;
            model_updates();
        end
        #1;
    endtask

    task automatic idle();
        fetch_valid   = '0;
        fetch_pc      = '0;
        upd_valid     = '0;
        upd_pc        = '0;
        upd_hist      = '0;
        upd_taken     = '0;
        upd_target    = '0;
        recover_valid = 1'b0;
        recover_hist  = '0;
        recover_taken = 1'b0;
    endtask

    task automatic set_fetch(logic [1:0] v, logic [XLEN-1:0] pc0, logic [XLEN-1:0] pc1);
        fetch_valid = v;
        fetch_pc    = {pc1, pc0};
    endtask

    task automatic set_upd(int j, logic [XLEN-1:0] pc, logic [HIST_LEN-1:0] h,
                           logic tk, logic [XLEN-1:0] tgt);
        upd_valid[j]                     = 1'b1;
        upd_pc[j*XLEN +: XLEN]           = pc;
        upd_hist[j*HIST_LEN +: HIST_LEN] = h;
        upd_taken[j]                     = tk;
        upd_target[j*XLEN +: XLEN]       = tgt;
    endtask

    task automatic set_recover(logic [HIST_LEN-1:0] h, logic tk);
        recover_valid = 1'b1;
        recover_hist  = h;
        recover_taken = tk;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clock);
        model_reset();
        #1;
        reset = 1'b0;

        // Cold lookups: no hits, fall-through targets, zero history
        set_fetch(2'b11, 32'h100, 32'h104);
        #1;
        check("cold.valid",  64'(pred_valid),  64'(2'b11));
        check("cold.taken",  64'(pred_taken),  64'(2'b00));
        check("cold.target", 64'(pred_target), {32'h108, 32'h104});
        check("cold.hist",   64'(pred_hist),   64'(16'h0000));
        step("cold");

        // First taken commit allocates; next lookup hits, is taken and blocks lane 1
        idle();
        set_upd(0, 32'h100, 8'h00, 1'b1, 32'h200);
        step("alloc");
        idle();
        set_fetch(2'b11, 32'h100, 32'h104);
        #1;
        check("hit.valid",  64'(pred_valid),          64'(2'b01));
        check("hit.taken",  64'(pred_taken),          64'(2'b01));
        check("hit.target", 64'(pred_target[31:0]),   64'(32'h200));
        step("hit");

        // Two not-taken commits to one counter in one cycle: 2 -> 0; one taken then gives 1
        idle();
        set_fetch(2'b01, 32'h200, 32'h0);
        set_upd(0, 32'h100, 8'h00, 1'b0, 32'h0);
        set_upd(1, 32'h100, 8'h00, 1'b0, 32'h0);
        set_recover(8'h00, 1'b0);
        #1;
        check("ghr_after_hit", 64'(pred_hist[7:0]), 64'(8'h01));
        step("double_nt");
        idle();
        set_upd(0, 32'h100, 8'h00, 1'b1, 32'h200);
        step("inc_once");
        idle();
        set_fetch(2'b11, 32'h100, 32'h104);
        set_upd(0, 32'h100, 8'h00, 1'b0, 32'h0);
        #1;
        check("double_nt.taken", 64'(pred_taken), 64'(2'b00));
        step("nt_to_zero");

        // Saturation at zero: extra not-taken keeps 0, so a single taken leaves it not-taken
        idle();
        set_upd(0, 32'h100, 8'h00, 1'b0, 32'h0);
        step("sat_nt");
        idle();
        set_upd(0, 32'h100, 8'h00, 1'b1, 32'h200);
        step("sat_inc");
        idle();
        set_fetch(2'b11, 32'h100, 32'h104);
        #1;
        check("sat.taken", 64'(pred_taken), 64'(2'b00));
        step("sat_look");

        // Two hits, lane 0 not-taken and lane 1 taken, starting from GHR 0x05
        idle();
        set_recover(8'h02, 1'b1);
        set_upd(0, 32'h104, 8'h0A, 1'b1, 32'h400);
        step("prep_two_hits");
        idle();
        set_fetch(2'b11, 32'h100, 32'h104);
        #1;
        check("two.hist",   64'(pred_hist),          64'(16'h0A05));
        check("two.taken",  64'(pred_taken),         64'(2'b10));
        check("two.valid",  64'(pred_valid),         64'(2'b11));
        check("two.target", 64'(pred_target[63:32]), 64'(32'h400));
        step("two_hits");
        idle();
        set_fetch(2'b01, 32'h200, 32'h0);
        set_recover(8'h02, 1'b1);
        #1;
        check("two.ghr_next", 64'(pred_hist[7:0]), 64'(8'h15));
        step("ghr_15");

        // Recovery in the same cycle as a taken fetch discards the fetch shift
        idle();
        set_fetch(2'b11, 32'h100, 32'h104);
        set_recover(8'h3C, 1'b1);
        #1;
        check("rec.taken", 64'(pred_taken), 64'(2'b10));
        step("recover");
        idle();
        set_fetch(2'b01, 32'h200, 32'h0);
        #1;
        check("rec.ghr", 64'(pred_hist[7:0]), 64'(8'h79));
        step("rec_look");

        // Tag replacement: 0x500 owns BTB index 0, then 0x100 takes it back with counter 2
        idle();
        set_upd(0, 32'h500, 8'h00, 1'b1, 32'h600);
        step("alloc_500");
        idle();
        set_upd(0, 32'h500, 8'h00, 1'b0, 32'h0);
        set_upd(1, 32'h500, 8'h00, 1'b0, 32'h0);
        step("drain_500");
        idle();
        set_upd(0, 32'h100, 8'h00, 1'b1, 32'h300);
        set_recover(8'h00, 1'b0);
        step("replace");
        idle();
        set_fetch(2'b11, 32'h500, 32'h100);
        #1;
        check("repl.taken",  64'(pred_taken),  64'(2'b10));
        check("repl.target", 64'(pred_target), {32'h300, 32'h504});
        check("repl.valid",  64'(pred_valid),  64'(2'b11));
        step("repl_look");

        // Random traffic against the model, with occasional resets and recoveries
        for (int n = 0; n < 600; n++) begin
            idle();
            reset       = ($urandom_range(0, 199) == 0);
            fetch_valid = WAY'($urandom_range(0, 3));
            for (int i = 0; i < WAY; i++) begin
                fetch_pc[i*XLEN +: XLEN] = XLEN'($urandom_range(0, 511) << 2);
            end
            for (int j = 0; j < UPD_W; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_upd(j, XLEN'($urandom_range(0, 511) << 2),
                            HIST_LEN'($urandom_range(0, 3)),
                            ($urandom_range(0, 9) < 6),
                            XLEN'($urandom() << 2));
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                set_recover(HIST_LEN'($urandom()), 1'($urandom_range(0, 1)));
            end
            step("rand");
        end
        reset = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- Parametrised fetch-stage direction and target predictor for the superscalar front end.
- Global-history (gshare) pattern table of saturating counters, indexed by PC XOR speculative global history.
- Tagged direct-mapped BTB supplies targets.
- Speculative history advances at fetch, is restored on mispredict, and is trained by in-order commit updates of up to UPD_W branches per cycle.

Parameters:
WAY, 2, fetch lanes looked up per cycle
UPD_W, 2, commit update lanes per cycle
XLEN, 32, PC width
HIST_LEN, 8, global history bits
PHT_IDX, 8, log2 pattern-table depth (PHT_IDX >= HIST_LEN)
BTB_IDX, 6, log2 BTB depth
CTR_BITS, 2, counter width (>= 2)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
fetch_valid  in  WAY  lane i looked up and consumed this cycle
fetch_pc  in  WAY*XLEN  lane PCs, lane 0 oldest
pred_valid  out  WAY  lane i valid and not behind an earlier predicted-taken lane
pred_taken  out  WAY  predicted taken
pred_target  out  WAY*XLEN  next PC for lane
pred_hist  out  WAY*HIST_LEN  history used to index lane i; carried down the pipe
upd_valid  in  UPD_W  committed branch in lane j, program order
upd_pc  in  UPD_W*XLEN  branch PC
upd_hist  in  UPD_W*HIST_LEN  pred_hist captured at fetch
upd_taken  in  UPD_W  actual direction
upd_target  in  UPD_W*XLEN  actual target
recover_valid  in  1  mispredict flush
recover_hist  in  HIST_LEN  pred_hist of the mispredicted branch
recover_taken  in  1  actual direction of that branch

Behaviour:
- Word-aligned PCs. BTB index is pc[BTB_IDX+1:2]; BTB tag is pc[XLEN-1:BTB_IDX+2].
- PHT index is pc[PHT_IDX+1:2] XOR zero-extended history.
- BTB entry holds valid, tag and target.
- Counter predicts taken when its MSB is 1. Counters saturate at 0 and 2^CTR_BITS-1.
- Reset:
  - GHR = 0 and all BTB valid bits = 0.
  - Every counter = 2^(CTR_BITS-1)-1 (weakly not-taken).
  - A reset in the middle of updates discards them. Outputs are combinational and reflect the reset state the following cycle.
- Lookup (combinational, zero latency):
  - Reads registered state only. There is no bypass of same-cycle updates.
  - Lane i is a branch if its BTB entry is valid with a matching tag (hit).
  - pred_taken[i] = hit AND counter MSB. pred_target = BTB target if taken, else fetch_pc+4.
  - h0 = GHR. h(i+1) = (h(i) << 1) | pred_taken[i] when lane i hits, else h(i+1) = h(i). pred_hist[i] = h(i).
  - pred_valid[i] = fetch_valid[i] and no earlier valid lane predicted taken. Lanes after the first taken lane produce no history shift.
- GHR next state, in priority order:
  - recover_valid: GHR <= (recover_hist << 1) | recover_taken. Same-cycle fetch shifts are discarded.
  - Else: GHR <= h after the last pred_valid lane.
  - No valid lanes: GHR holds.
- Update (registered; visible to lookups the next cycle):
  - Lanes are processed in order 0..UPD_W-1. A later lane sees the state written by earlier lanes, so two lanes hitting one PHT index step that counter twice.
  - Counter at (upd_pc XOR upd_hist): +1 if taken, -1 if not, saturating.
  - BTB, taken update:
    - Tag mismatch or invalid entry: write valid, tag and target, and reset the PHT counter at that lane's index to weakly taken (2^(CTR_BITS-1)) instead of incrementing it.
    - Tag match: overwrite the target if it differs.
  - BTB, not-taken update: no BTB allocation; the counter is still trained.
- Recovery and updates in the same cycle are independent; both apply.

Optional Feature:
- BP_STATS_EN defined adds outputs stat_lookups, stat_taken and stat_recovers, each 32 bits. Per cycle they add the count of pred_valid lanes, the count of pred_taken lanes, and 1 per recover_valid cycle. They wrap at 2^32 and reset to 0.
- BP_STATS_EN undefined: these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then fetch 0x100 and 0x104 -> pred_valid=11, pred_taken=00, targets 0x104 and 0x108, pred_hist=0,0, and GHR stays 0 (no hits).
- Update 0x100 taken, target 0x200, hist 0 -> next cycle fetch 0x100 with GHR 0: hit, counter=2, pred_taken=1, target 0x200, lane 1 pred_valid=0, GHR becomes 0x01.
- Two updates in one cycle, same PC 0x100 and hist 0, both not-taken, starting from counter 2 -> counter 0. A third not-taken update keeps it at 0 (saturation).
- Fetch with two BTB hits, lane 0 not-taken and lane 1 taken, GHR=0x05 -> pred_hist=0x05,0x0A, and GHR next = 0x15.
- recover_valid with recover_hist=0x3C and recover_taken=1, asserted in the same cycle as a taken fetch -> GHR=0x79 and the fetch shift is discarded.
- Taken update to 0x100 with target 0x300 after an existing entry for 0x500 at the same BTB index -> tag replaced, counter reset to 2, and lookup of 0x500 misses.
